// File: rtl/rf_access_arbiter_pkg.sv
// Purpose: shared types/constants for the register-file access arbiter (state encoding, RF geometry).
// Latency: n/a (types and constants only).
// Backpressure: n/a. Ports: none.
package rf_ctrl_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WAIT_W     = 8;  // wait counter width, covers MAX_WAIT up to 255

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_PEND,
    ST_FORCE,
    ST_RESP
  } arb_state_t;

endpackage

// File: rtl/rf_access_arbiter_if.sv
// Purpose: bundles pipeline, debug and register-file port signals of the access arbiter.
// Latency: n/a (wires only). Backpressure: debug side holds dbg_req until dbg_ack.
// Ports: slave = arbiter side, master = environment side (pipeline/debug unit/register file).
interface rf_access_arbiter_if #(
  parameter int N = 32
);
  import rf_ctrl_pkg::*;

  // pipeline side
  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [N-1:0]          wb_data;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs2_used;
  // debug side
  logic                  dbg_req;
  logic                  dbg_we;
  logic [REG_ADDR_W-1:0] dbg_addr;
  logic [N-1:0]          dbg_wdata;
  logic                  dbg_ack;
  logic [N-1:0]          dbg_rdata;
  logic                  stall_req;
  // register file side
  logic                  rf_write_enable;
  logic [REG_ADDR_W-1:0] rf_reg_write;
  logic [N-1:0]          rf_write_data;
  logic [REG_ADDR_W-1:0] rf_reg_read2;
  logic [N-1:0]          rf_read_data_2;

  modport slave (
    input  wb_we, wb_rd, wb_data, id_rs2, id_rs2_used,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata, stall_req,
    output rf_write_enable, rf_reg_write, rf_write_data, rf_reg_read2,
    input  rf_read_data_2
  );

  modport master (
    output wb_we, wb_rd, wb_data, id_rs2, id_rs2_used,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata, stall_req,
    input  rf_write_enable, rf_reg_write, rf_write_data, rf_reg_read2,
    output rf_read_data_2
  );

endinterface

// File: rtl/rf_access_arbiter_init_sweep.sv
// Purpose: post-reset sweep counter 1..31 giving the register index to zero and a done flag.
// Latency: one index per enabled cycle, done is combinational on the final index.
// Backpressure: none; counter parks on the last index until the next reset.
// Ports: clk, rst_n, en (sweep active), done, addr (register being zeroed).
module rf_init_sweep
  import rf_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  done,
  output logic [REG_ADDR_W-1:0] addr
);

  logic [REG_ADDR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= REG_ADDR_W'(1);
    end else if (en && !done) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == REG_ADDR_W'(REG_COUNT - 1));
  assign addr = cnt;

endmodule

// File: rtl/rf_access_arbiter.sv
// Purpose: shares the RF write port and read port 2 between pipeline (priority) and debug requests.
// Latency: debug access one cycle after dbg_req is sampled, dbg_ack the cycle after; stall after MAX_WAIT deferrals.
// Backpressure: dbg_req held until dbg_ack; stall_req freezes the pipeline when a debug access starves.
// Ports: clk, rst_n, bus (rf_access_arbiter_if.slave). Macro RF_INIT_SWEEP_EN adds a post-reset zeroing sweep of x1..x31.
module rf_access_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int N        = 32,
  parameter int MAX_WAIT = 8
) (
  input logic                clk,
  input logic                rst_n,
  rf_access_arbiter_if.slave bus
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;
`ifdef RF_INIT_SWEEP_EN
  localparam arb_state_t RESET_STATE = ST_INIT;
`else
  localparam arb_state_t RESET_STATE = ST_IDLE;
`endif

  arb_state_t            state, state_d;
  logic                  req_we;
  logic [REG_ADDR_W-1:0] req_addr;
  logic [N-1:0]          req_wdata;
  logic [WAIT_W-1:0]     wait_cnt, wait_inc;
  logic [N-1:0]          rdata_q;
  logic                  slot_free, access;
  logic                  ack, stall, we;
  logic [REG_ADDR_W-1:0] wa, ra;
  logic [N-1:0]          wd;

  // The port the pending request needs is free when its pipeline owner is idle.
  assign slot_free = req_we ? !bus.wb_we : !bus.id_rs2_used;
  assign wait_inc  = (wait_cnt == WAIT_SAT) ? wait_cnt : wait_cnt + 1'b1;

`ifdef RF_INIT_SWEEP_EN
  logic                  sweep_done;
  logic [REG_ADDR_W-1:0] sweep_addr;

  rf_init_sweep u_sweep (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == ST_INIT),
    .done (sweep_done),
    .addr (sweep_addr)
  );
`endif

  always_comb begin
    state_d = state;
    access  = 1'b0;
    ack     = 1'b0;
    stall   = 1'b0;
    we      = bus.wb_we;
    wa      = bus.wb_rd;
    wd      = bus.wb_data;
    ra      = bus.id_rs2;
    case (state)
`ifdef RF_INIT_SWEEP_EN
      ST_INIT: begin
        stall = 1'b1;
        // Port stays a passthrough while reset is held; sweep writes only once released.
        if (rst_n) begin
          we = 1'b1;
          wa = sweep_addr;
          wd = '0;
        end
        if (sweep_done) state_d = ST_IDLE;
      end
`endif
      ST_IDLE: begin
        if (bus.dbg_req) state_d = ST_PEND;
      end
      ST_PEND, ST_FORCE: begin
        stall = (state == ST_FORCE);
        if (slot_free) begin
          access  = 1'b1;
          state_d = ST_RESP;
          if (req_we) begin
            // x0 is hardwired; the access completes but nothing is written.
            we = (req_addr != '0);
            wa = req_addr;
            wd = req_wdata;
          end else begin
            ra = req_addr;
          end
        end else if (wait_inc >= WAIT_LIMIT) begin
          state_d = ST_FORCE;
        end
      end
      ST_RESP: begin
        ack     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_STATE;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      wait_cnt  <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_d;
      if (state == ST_IDLE && bus.dbg_req) begin
        req_we    <= bus.dbg_we;
        req_addr  <= bus.dbg_addr;
        req_wdata <= bus.dbg_wdata;
        wait_cnt  <= '0;
      end else if ((state == ST_PEND || state == ST_FORCE) && !slot_free) begin
        wait_cnt <= wait_inc;
      end
      if (access && !req_we) begin
        rdata_q <= (req_addr == '0) ? '0 : bus.rf_read_data_2;
      end
    end
  end

  assign bus.dbg_ack         = ack;
  assign bus.dbg_rdata       = rdata_q;
  assign bus.stall_req       = stall;
  assign bus.rf_write_enable = we;
  assign bus.rf_reg_write    = wa;
  assign bus.rf_write_data   = wd;
  assign bus.rf_reg_read2    = ra;

endmodule
